// File: rtl/sysbus_pkg.sv
// Shared Sysbus arbiter types: FSM state, owner identity and default geometry.
package sysbus_pkg;

    localparam int unsigned BEATS_DEF  = 8;
    localparam int unsigned TAG_W_DEF  = 13;
    localparam int unsigned TAG_RW_BIT = TAG_W_DEF - 1;  // 1 = READ, 0 = WRITE

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing one Sysbus master port between fetch and data units;
// one transaction at a time, address latched at grant, beats steered to the owner.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned BEATS  = BEATS_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              f_reqcyc,
    input  logic [DATA_W-1:0] f_req,
    input  logic [TAG_W-1:0]  f_reqtag,
    output logic              f_reqack,
    output logic              f_respcyc,
    output logic [DATA_W-1:0] f_resp,
    input  logic              f_respack,

    input  logic              d_reqcyc,
    input  logic [DATA_W-1:0] d_req,
    input  logic [TAG_W-1:0]  d_reqtag,
    output logic              d_reqack,
    output logic              d_respcyc,
    output logic [DATA_W-1:0] d_resp,
    input  logic              d_respack,

    output logic              m_reqcyc,
    output logic [DATA_W-1:0] m_req,
    output logic [TAG_W-1:0]  m_reqtag,
    input  logic              m_reqack,
    input  logic              m_respcyc,
    input  logic [DATA_W-1:0] m_resp,
    output logic              m_respack
);

    localparam int unsigned       CNT_W     = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q,  last_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] addr_q,  addr_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;

    logic              own_reqcyc;
    logic [DATA_W-1:0] own_req;
    logic              own_respack;
    logic              own_reqack;
    logic              own_respcyc;
    logic [DATA_W-1:0] own_resp;
    owner_t            grant;

    // On a tie the requester that did not win last time gets the bus.
    function automatic owner_t rr_grant(input logic f, input logic d, input owner_t last);
        if (f && d)
            return (last == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        else if (d)
            return OWN_DATA;
        else
            return OWN_FETCH;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        m_reqcyc    = 1'b0;
        m_req       = '0;
        m_reqtag    = '0;
        m_respack   = 1'b0;
        own_reqack  = 1'b0;
        own_respcyc = 1'b0;
        own_resp    = '0;

        own_reqcyc  = (owner_q == OWN_DATA) ? d_reqcyc  : f_reqcyc;
        own_req     = (owner_q == OWN_DATA) ? d_req     : f_req;
        own_respack = (owner_q == OWN_DATA) ? d_respack : f_respack;
        grant       = rr_grant(f_reqcyc, d_reqcyc, last_q);

        unique case (state_q)
            ST_IDLE: begin
                if (f_reqcyc || d_reqcyc) begin
                    owner_d = grant;
                    addr_d  = (grant == OWN_DATA) ? d_req    : f_req;
                    tag_d   = (grant == OWN_DATA) ? d_reqtag : f_reqtag;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_reqcyc = 1'b1;
                m_req    = addr_q;
                m_reqtag = tag_q;
                if (m_reqack) begin
                    own_reqack = 1'b1;
                    last_d     = owner_q;
                    cnt_d      = '0;
                    state_d    = tag_q[TAG_W-1] ? ST_RESP : ST_WDATA;
                end
            end
            ST_WDATA: begin
                m_reqcyc   = own_reqcyc;
                m_req      = own_req;
                m_reqtag   = tag_q;
                own_reqack = m_reqack;
                if (m_reqack && own_reqcyc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT)
                        state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                own_respcyc = m_respcyc;
                own_resp    = m_resp;
                m_respack   = own_respack;
                if (m_respcyc && own_respack) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT)
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        f_reqack  = own_reqack  && (owner_q == OWN_FETCH);
        d_reqack  = own_reqack  && (owner_q == OWN_DATA);
        f_respcyc = own_respcyc && (owner_q == OWN_FETCH);
        d_respcyc = own_respcyc && (owner_q == OWN_DATA);
        f_resp    = (owner_q == OWN_FETCH) ? own_resp : '0;
        d_resp    = (owner_q == OWN_DATA)  ? own_resp : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_FETCH;
            last_q  <= OWN_DATA;
            cnt_q   <= '0;
            addr_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
        end
    end

    // A response beat with no read in flight means the bus and arbiter disagree.
    assert property (@(posedge clk) disable iff (!reset) !(m_respcyc && state_q != ST_RESP))
        else $fatal(1, "sysbus_arbiter: m_respcyc asserted outside RESP");

endmodule
